// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC controller: default parameters,
// conversion state encoding and counter-width helpers.
package sar_pkg;

    localparam int unsigned DEF_WIDTH         = 8;
    localparam int unsigned DEF_SETTLE        = 1;
    localparam int unsigned DEF_SAMPLE_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_TRIAL  = 2'd2
    } sar_state_e;

    // Bit-index counter width; WIDTH >= 2 keeps this at least 1.
    function automatic int unsigned idx_width(input int unsigned width);
        return $clog2(width);
    endfunction

    // Shared settle/sample counter width, sized for the longer of the two phases.
    function automatic int unsigned cnt_width(input int unsigned settle,
                                              input int unsigned sample_cycles);
        int unsigned m;
        m = (settle > sample_cycles) ? settle : sample_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sar_result_reg.sv
// Result holding register for the SAR controller.
// Ports: clk/rst (sync active-high), load_i + code_i (new conversion code),
//        ready_i (consumer accept), result_o/valid_o (held result),
//        overrun_o (sticky: a load overwrote an unconsumed result).
module sar_result_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] code_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] r_result;
    logic             r_valid;
    logic             r_overrun;

    // A load wins over a same-edge handshake; overrun only when nobody took the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (load_i) begin
            r_result <= code_i;
            r_valid  <= 1'b1;
            if (r_valid && !ready_i) begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign result_o  = r_result;
    assign valid_o   = r_valid;
    assign overrun_o = r_overrun;

endmodule

// File: rtl/sar_adc_ctrl.sv
// Parametrised successive-approximation ADC controller.
// Ports: clk/rst (sync active-high); start_i, cont_i, abort_i control;
//        cmp_i comparator (1 = keep trial bit); dac_o trial code;
//        sample_o track/hold; busy_o not idle; result_o/valid_o/ready_i
//        result handshake; overrun_o sticky overwrite flag.
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned SETTLE        = DEF_SETTLE,
    parameter int unsigned SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic             abort_i,
    input  logic             cmp_i,
    output logic [WIDTH-1:0] dac_o,
    output logic             sample_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overrun_o
);

    localparam int unsigned KW = idx_width(WIDTH);
    localparam int unsigned CW = cnt_width(SETTLE, SAMPLE_CYCLES);

    localparam logic [KW-1:0] K_TOP       = KW'(WIDTH - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);

    sar_state_e       r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt,   w_cnt_nxt;
    logic [KW-1:0]    r_k,     w_k_nxt;
    logic [WIDTH-1:0] r_code,  w_code_nxt;

    logic [WIDTH-1:0] w_trial_bit;
    logic [WIDTH-1:0] w_trial_code;
    logic [WIDTH-1:0] w_kept_code;
    logic             w_load;

    // r_code only ever holds decided bits above k, so "clear" is just r_code.
    assign w_trial_bit  = WIDTH'(1) << r_k;
    assign w_trial_code = r_code | w_trial_bit;
    assign w_kept_code  = cmp_i ? w_trial_code : r_code;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_k     <= '0;
            r_code  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_k     <= w_k_nxt;
            r_code  <= w_code_nxt;
        end
    end

    // Next-state logic; abort beats completion and start.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        w_code_nxt  = r_code;
        w_load      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt  = '0;
                w_code_nxt = '0;
                if (start_i) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                if (abort_i) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_code_nxt  = '0;
                end else if (r_cnt == SAMPLE_LAST) begin
                    w_state_nxt = ST_TRIAL;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = K_TOP;
                    w_code_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            ST_TRIAL: begin
                if (abort_i) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_code_nxt  = '0;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_cnt_nxt  = '0;
                    w_code_nxt = w_kept_code;
                    if (r_k == '0) begin
                        w_load      = 1'b1;
                        w_code_nxt  = '0;
                        w_state_nxt = cont_i ? ST_SAMPLE : ST_IDLE;
                    end else begin
                        w_k_nxt = r_k - KW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_code_nxt  = '0;
            end
        endcase
    end

    // Analog-side outputs are pure decodes of registered state.
    assign dac_o    = (r_state == ST_TRIAL) ? w_trial_code : '0;
    assign sample_o = (r_state == ST_SAMPLE);
    assign busy_o   = (r_state != ST_IDLE);

    sar_result_reg #(
        .WIDTH (WIDTH)
    ) u_result (
        .clk       (clk),
        .rst       (rst),
        .load_i    (w_load),
        .code_i    (w_kept_code),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .valid_o   (valid_o),
        .overrun_o (overrun_o)
    );

endmodule

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Parametrised successive-approximation ADC controller; the next generation of our fixed 8-bit SAR.
- Generalises resolution, DAC settle time and track/hold time.
- Adds continuous conversion, abort, and a valid/ready result port with sticky overrun detection.
- Sits between the analog comparator/DAC macro and the digital consumer of conversion codes.

## Interface
- WIDTH, 8: conversion resolution in bits; ≥2.
- SETTLE, 1: cycles each trial code is held on dac_o before cmp_i is sampled; ≥1.
- SAMPLE_CYCLES, 2: cycles sample_o is held high (track phase) before bit trials; ≥1.
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request a conversion; accepted only in IDLE.
- cont_i  in  1  continuous mode; sampled at each conversion end.
- abort_i  in  1  cancel any conversion in progress.
- cmp_i  in  1  comparator output; 1 = analog input ≥ DAC(dac_o), i.e. keep the trial bit.
- dac_o  out  WIDTH  trial code driven to the DAC.
- sample_o  out  1  track/hold control; high during SAMPLE.
- busy_o  out  1  high whenever state ≠ IDLE.
- result_o  out  WIDTH  last completed conversion code.
- valid_o  out  1  result_o holds an unconsumed result.
- ready_i  in  1  consumer accepts result_o when valid_o && ready_i.
- overrun_o  out  1  sticky; a completed result overwrote an unconsumed one.

## Operation
- States: IDLE, SAMPLE, TRIAL.
- IDLE: dac_o=0, sample_o=0. start_i=1 → SAMPLE.
- SAMPLE: sample_o=1, dac_o=0 for exactly SAMPLE_CYCLES cycles → TRIAL with bit index k=WIDTH-1 and an accumulated code of 0.
- TRIAL: dac_o = accumulated code | (1<<k), held for SETTLE cycles.
  - On the edge ending the SETTLE-th cycle, cmp_i is sampled. If 1, bit k is kept in the accumulated code; if 0, it is cleared.
  - If k>0: k decrements and the settle counter restarts.
  - If k=0: the final code loads result_o and valid_o goes to 1. The next state is SAMPLE if cont_i=1, else IDLE.
- Result port:
  - valid_o clears on the handshake edge (valid_o && ready_i) unless a new result loads on the same edge; the new result wins and valid_o stays 1 with no overrun.
  - A result loading while valid_o=1 and ready_i=0 overwrites result_o and sets overrun_o.
  - overrun_o clears only on rst.
- abort_i=1 in SAMPLE/TRIAL: next state IDLE, accumulated code discarded, dac_o=0, sample_o=0. result_o, valid_o and overrun_o are unaffected. abort_i has priority over start_i and over completion on the same edge; an aborted final bit loads no result.
- start_i outside IDLE is ignored. start_i is not required for continuous restarts.
- Counter widths: k uses $clog2(WIDTH); settle and sample counters use $clog2(max(SETTLE,SAMPLE_CYCLES)+1). There is no arithmetic on codes beyond bit set/clear.

## Timing
- Reset values: dac_o=0, sample_o=0, busy_o=0, result_o=0, valid_o=0, overrun_o=0, state IDLE.
- Reset mid-conversion returns to IDLE on the same edge, with the values above.
- All outputs are registered or are decodes of registered state; no combinational path from any input to any output.
- Cycle numbering: the cycle in which start_i is sampled in IDLE is cycle 0.
  - sample_o is high in cycles 1..SAMPLE_CYCLES.
  - The trial for bit k occupies SETTLE cycles.
  - valid_o first goes high in cycle 1+SAMPLE_CYCLES+WIDTH·SETTLE; this is 11 for the defaults.
- Continuous mode throughput: one result every SAMPLE_CYCLES+WIDTH·SETTLE cycles; SAMPLE begins the cycle valid_o rises.
- busy_o is high from cycle 1 through the last trial cycle. It drops the cycle valid_o rises, unless in continuous mode.

## Structure
- Package sar_pkg holds:
  - the state enum (IDLE, SAMPLE, TRIAL);
  - localparam helpers for counter widths;
  - the default WIDTH, SETTLE and SAMPLE_CYCLES constants.
- One sub-module is natural: sar_result_reg, the WIDTH-wide result holding register. It owns the valid/ready handshake, overwrite-on-load and sticky overrun logic. The conversion FSM and counters stay in sar_adc_ctrl.

## Test plan
- Defaults; comparator model cmp_i=(0xA5 ≥ dac_o); start_i pulse at cycle 0 → dac_o sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5. result_o=0xA5 and valid_o=1 in cycle 11; busy_o=0 in cycle 11.
- Boundary inputs: model 0x00 → result 0x00; model 0xFF → result 0xFF. Also WIDTH=12, model 0x800 → result 0x800.
- SETTLE=3, SAMPLE_CYCLES=1: each dac_o code held 3 cycles; valid_o in cycle 26. A cmp_i glitch in a non-final settle cycle does not affect the result.
- Continuous mode, cont_i=1, ready_i=0, model 0x3C: first result valid at cycle 11, with overrun_o=0. The second result loads at cycle 21 and overrun_o=1. Then ready_i=1 → valid_o clears; overrun_o stays 1.
- abort_i asserted during the trial of bit 4 → IDLE next edge, dac_o=0, valid_o unchanged. A new start_i then converts normally.
- rst asserted mid-TRIAL with valid_o=1 → all outputs 0 next edge. A subsequent start_i produces a correct result with correct latency.
